// File: rtl/score_tracker.sv
// ============================================================================
//  Module   : score_tracker
//  Brief    : Right/wrong guess counter with win/lose game FSM, new-game
//             restart and one-count-per-press edge detection.
//             Optional SCORE_DEBOUNCE_EN adds a synchroniser + debouncer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_tracker #(
    parameter int MAX_SCORE = 4
`ifdef SCORE_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 1_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       guess_in,
    input  logic       guess_correct,
    input  logic       new_game,
    output logic [2:0] right,
    output logic [2:0] wrong,
    output logic       result_valid,
    output logic       last_correct,
    output logic       win,
    output logic       lose
);

    localparam logic [2:0] c_max_score = 3'(MAX_SCORE);

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_WIN  = 2'd1,
        S_LOSE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_g_q;
    logic       w_guess_lvl;
    logic       w_rise;
    logic       w_accept;
    logic [2:0] w_right_next;
    logic [2:0] w_wrong_next;
    logic       w_valid_next;
    logic       w_last_next;

`ifdef SCORE_DEBOUNCE_EN
    localparam logic [19:0] c_db_last = 20'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  r_sync;
    logic [19:0] r_db_cnt;
    logic        r_db_lvl;

    // Level flips only after the synchronised input disagrees with it for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_db_cnt <= 20'd0;
            r_db_lvl <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], guess_in};
            if (r_sync[1] == r_db_lvl) begin
                r_db_cnt <= 20'd0;
            end else if (r_db_cnt == c_db_last) begin
                r_db_lvl <= r_sync[1];
                r_db_cnt <= 20'd0;
            end else begin
                r_db_cnt <= r_db_cnt + 20'd1;
            end
        end
    end

    assign w_guess_lvl = r_db_lvl;
`else
    assign w_guess_lvl = guess_in;
`endif

    assign w_rise   = w_guess_lvl & ~r_g_q;
    assign w_accept = w_rise & (r_state == S_PLAY) & ~new_game;

    always_comb begin
        w_state_next = r_state;
        w_right_next = right;
        w_wrong_next = wrong;
        w_valid_next = 1'b0;
        w_last_next  = last_correct;
        if (new_game) begin
            // Restart wins over any guess arriving in the same cycle.
            w_state_next = S_PLAY;
            w_right_next = 3'd0;
            w_wrong_next = 3'd0;
            w_last_next  = 1'b0;
        end else if (w_accept) begin
            w_valid_next = 1'b1;
            w_last_next  = guess_correct;
            if (guess_correct) begin
                w_right_next = right + 3'd1;
                if (w_right_next == c_max_score) begin
                    w_state_next = S_WIN;
                end
            end else begin
                w_wrong_next = wrong + 3'd1;
                if (w_wrong_next == c_max_score) begin
                    w_state_next = S_LOSE;
                end
            end
        end
    end

    // g_q resets high so a button already held through reset is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_PLAY;
            r_g_q        <= 1'b1;
            right        <= 3'd0;
            wrong        <= 3'd0;
            result_valid <= 1'b0;
            last_correct <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_g_q        <= w_guess_lvl;
            right        <= w_right_next;
            wrong        <= w_wrong_next;
            result_valid <= w_valid_next;
            last_correct <= w_last_next;
            win          <= (w_state_next == S_WIN);
            lose         <= (w_state_next == S_LOSE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_score_tracker.sv
// ============================================================================
//  Module   : tb_score_tracker
//  Brief    : Directed self-checking bench for score_tracker (MAX_SCORE=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_tracker;

    logic       clk;
    logic       rst;
    logic       guess_in;
    logic       guess_correct;
    logic       new_game;
    logic [2:0] right;
    logic [2:0] wrong;
    logic       result_valid;
    logic       last_correct;
    logic       win;
    logic       lose;

    int n_checks = 0;
    int n_errors = 0;

    score_tracker #(.MAX_SCORE(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .guess_in     (guess_in),
        .guess_correct(guess_correct),
        .new_game     (new_game),
        .right        (right),
        .wrong        (wrong),
        .result_valid (result_valid),
        .last_correct (last_correct),
        .win          (win),
        .lose         (lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic press(input logic c);
        guess_in      = 1'b1;
        guess_correct = c;
        @(negedge clk);
        guess_in      = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_right"}, 8'(right), 8'd0);
        check({tag, "_wrong"}, 8'(wrong), 8'd0);
        check({tag, "_win"},   8'(win), 8'd0);
        check({tag, "_lose"},  8'(lose), 8'd0);
        check({tag, "_valid"}, 8'(result_valid), 8'd0);
    endtask

    initial begin
        int exp_r;
        int exp_w;
        int pulses;
        logic [6:0] seq;

        rst = 1'b1; guess_in = 1'b0; guess_correct = 1'b0; new_game = 1'b0;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset");
        check("reset_last", 8'(last_correct), 8'd0);

        // Three correct presses, then the winning fourth.
        for (int i = 1; i <= 3; i++) begin
            press(1'b1);
            check("win_seq_right", 8'(right), 8'(i));
            check("win_seq_valid", 8'(result_valid), 8'd1);
            check("win_seq_last", 8'(last_correct), 8'd1);
            check("win_seq_win", 8'(win), 8'd0);
            idle(1);
            check("win_seq_valid_drop", 8'(result_valid), 8'd0);
            idle(1);
        end
        press(1'b1);
        check("fourth_right", 8'(right), 8'd4);
        check("fourth_win", 8'(win), 8'd1);
        check("fourth_valid", 8'(result_valid), 8'd1);
        idle(2);
        press(1'b1);
        check("fifth_right", 8'(right), 8'd4);
        check("fifth_valid", 8'(result_valid), 8'd0);
        check("fifth_win", 8'(win), 8'd1);
        idle(2);

        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check_zero("ng1");
        idle(1);

        // W C W C W C W -> wrong 4, right 3, lose.
        seq = 7'b0101010;
        exp_r = 0; exp_w = 0;
        for (int i = 6; i >= 0; i--) begin
            press(seq[i]);
            if (seq[i]) exp_r++; else exp_w++;
            check("alt_right", 8'(right), 8'(exp_r));
            check("alt_wrong", 8'(wrong), 8'(exp_w));
            check("alt_last", 8'(last_correct), 8'(seq[i]));
            idle(2);
        end
        check("lose_flag", 8'(lose), 8'd1);
        check("lose_win", 8'(win), 8'd0);
        press(1'b1);
        check("lose_hold_right", 8'(right), 8'd3);
        check("lose_hold_valid", 8'(result_valid), 8'd0);
        idle(2);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check_zero("ng2");
        idle(1);

        // Held button counts once.
        pulses = 0;
        guess_in = 1'b1; guess_correct = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        guess_in = 1'b0;
        check("hold_wrong", 8'(wrong), 8'd1);
        check("hold_pulses", 8'(pulses), 8'd1);
        idle(2);

        // Rise coincident with new_game is dropped; a later rise counts.
        new_game = 1'b1; guess_in = 1'b1; guess_correct = 1'b1;
        @(negedge clk);
        new_game = 1'b0; guess_in = 1'b0;
        check_zero("collide");
        @(negedge clk);
        check("collide_no_defer", 8'(right), 8'd0);
        check("collide_no_valid", 8'(result_valid), 8'd0);
        press(1'b1);
        check("after_collide_right", 8'(right), 8'd1);
        check("after_collide_valid", 8'(result_valid), 8'd1);
        idle(2);
        press(1'b1);
        check("pre_rst_right", 8'(right), 8'd2);
        idle(2);

        // Mid-game reset with the button held through release.
        rst = 1'b1; guess_in = 1'b1; guess_correct = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrst");
        check("midrst_last", 8'(last_correct), 8'd0);
        idle(3);
        check("held_thru_rst_right", 8'(right), 8'd0);
        check("held_thru_rst_valid", 8'(result_valid), 8'd0);
        guess_in = 1'b0;
        idle(1);
        press(1'b0);
        check("post_rst_wrong", 8'(wrong), 8'd1);
        check("post_rst_last", 8'(last_correct), 8'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
